// File: rtl/ai_car_lane_gen.sv
// One AI traffic car: spawn / scroll / lane-change / crash state machine plus a
// one-cycle pixel query path over a recolourable 16x16 2-bit sprite.
module ai_car_lane_gen #(
    parameter int         NUM_LANES      = 4,
    parameter int         LANE_X0        = 180,
    parameter int         LANE_PITCH     = 60,
    parameter int         SCALE_LOG2     = 2,
    parameter int         SCREEN_H       = 480,
    parameter int         BASE_SPEED     = 6,
    parameter int         SPEED_SHIFT    = 5,
    parameter int         SHIFT_STEP     = 2,
    parameter bit         LANE_CHANGE_EN = 1'b1,
    parameter int         CRASH_FRAMES   = 30,
    parameter logic [7:0] BODY_COLOR     = 8'hE4,
    parameter logic [7:0] MASK_VALUE     = 8'h62
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               frame_start,
    input  logic [10:0]        requested_x,
    input  logic [10:0]        requested_y,
    input  logic [9:0]         player_speed,
    input  logic [10:0]        random,
    input  logic               hit,
    output logic [10:0]        car_x,
    output logic signed [11:0] car_y,
    output logic               car_active,
    output logic               draw_request,
    output logic [7:0]         output_color
);

    localparam int                 CAR_W  = 16 << SCALE_LOG2;
    localparam logic signed [11:0] Y_MIN  = 12'(-CAR_W);
    localparam logic signed [11:0] Y_MAX  = 12'(SCREEN_H);
    localparam logic signed [12:0] CAR_SZ = 13'(CAR_W);

    // Row r, column c lives in bits [2c+1:2c]; 0 transparent, 1 body, 2 glass, 3 bumper.
    localparam logic [31:0] SPRITE [16] = '{
        32'h0000_0000, 32'h3FFF_FFFC, 32'h1555_5554, 32'h1555_5554,
        32'h16AA_AA94, 32'h16AA_AA94, 32'h1555_5554, 32'h1555_5554,
        32'h1555_5554, 32'h1555_5554, 32'h1555_5554, 32'h1555_5554,
        32'h1555_5554, 32'h1555_5554, 32'h3FFF_FFFC, 32'h0000_0000
    };

    typedef enum logic [1:0] {S_WAIT, S_DRIVE, S_SHIFT, S_CRASH} state_t;

    state_t             r_state, w_state_nxt;
    logic [4:0]         r_gap, w_gap_nxt;
    logic [2:0]         r_lane, w_lane_nxt, r_target, w_target_nxt;
    logic [10:0]        r_car_x, w_x_nxt;
    logic signed [11:0] r_car_y, w_y_nxt;
    logic [7:0]         r_crash_cnt, w_cnt_nxt;
    logic               r_draw_p1;
    logic [7:0]         r_color_p1;

    function automatic logic [10:0] lane_x(input logic [2:0] lane);
        lane_x = 11'(LANE_X0 + int'(lane) * LANE_PITCH);
    endfunction

    logic [11:0]        w_speed_add;
    logic signed [11:0] w_y_scroll;
    logic               w_despawn, w_to_wait, w_tgt_ok, w_lane_req;
    logic [2:0]         w_spawn_lane, w_tgt;
    logic [10:0]        w_x_step;
    logic [7:0]         w_cnt_inc;

    assign w_speed_add  = {2'b00, player_speed >> SPEED_SHIFT};
    assign w_y_scroll   = r_car_y + $signed(w_speed_add) - $signed(12'(BASE_SPEED));
    assign w_despawn    = (w_y_scroll >= Y_MAX) || (w_y_scroll < Y_MIN);
    assign w_spawn_lane = 3'(int'(random) % NUM_LANES);
    assign w_tgt        = random[7] ? r_lane + 3'd1 : r_lane - 3'd1;
    assign w_tgt_ok     = random[7] ? (int'(r_lane) < NUM_LANES - 1) : (r_lane != 3'd0);
    assign w_lane_req   = LANE_CHANGE_EN && (random[10:8] == 3'd0) && w_tgt_ok;
    assign w_x_step     = (r_target > r_lane) ? r_car_x + 11'(SHIFT_STEP)
                                              : r_car_x - 11'(SHIFT_STEP);
    assign w_cnt_inc    = r_crash_cnt + 8'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_WAIT;
            r_gap       <= 5'd1;
            r_lane      <= 3'd0;
            r_target    <= 3'd0;
            r_car_x     <= 11'(LANE_X0);
            r_car_y     <= Y_MIN;
            r_crash_cnt <= 8'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_gap       <= w_gap_nxt;
            r_lane      <= w_lane_nxt;
            r_target    <= w_target_nxt;
            r_car_x     <= w_x_nxt;
            r_car_y     <= w_y_nxt;
            r_crash_cnt <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_gap_nxt    = r_gap;
        w_lane_nxt   = r_lane;
        w_target_nxt = r_target;
        w_x_nxt      = r_car_x;
        w_y_nxt      = r_car_y;
        w_cnt_nxt    = r_crash_cnt;
        w_to_wait    = 1'b0;
        if (r_state == S_WAIT) begin
            if (frame_start) begin
                if (r_gap == 5'd0) begin
                    w_lane_nxt  = w_spawn_lane;
                    w_x_nxt     = lane_x(w_spawn_lane);
                    w_y_nxt     = Y_MIN;
                    w_state_nxt = S_DRIVE;
                end else begin
                    w_gap_nxt = r_gap - 5'd1;
                end
            end
        end else begin
            if (frame_start) w_y_nxt = w_y_scroll;
            // Leaving the screen wins over crash, lane change and crash timeout.
            if (frame_start && w_despawn) begin
                w_to_wait = 1'b1;
            end else begin
                case (r_state)
                    S_DRIVE: begin
                        if (hit) begin
                            w_state_nxt = S_CRASH;
                            w_cnt_nxt   = 8'd0;
                        end else if (frame_start && w_lane_req) begin
                            w_target_nxt = w_tgt;
                            w_state_nxt  = S_SHIFT;
                        end
                    end
                    S_SHIFT: begin
                        if (hit) begin
                            w_state_nxt = S_CRASH;
                            w_cnt_nxt   = 8'd0;
                        end else if (frame_start) begin
                            w_x_nxt = w_x_step;
                            if (w_x_step == lane_x(r_target)) begin
                                w_lane_nxt  = r_target;
                                w_state_nxt = S_DRIVE;
                            end
                        end
                    end
                    S_CRASH: begin
                        if (frame_start) begin
                            w_cnt_nxt = w_cnt_inc;
                            if (w_cnt_inc == 8'(CRASH_FRAMES)) w_to_wait = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
        if (w_to_wait) begin
            w_state_nxt = S_WAIT;
            w_gap_nxt   = {1'b0, random[3:0]} + 5'd1;
        end
    end

    logic signed [12:0] w_dx, w_dy;
    logic               w_inside, w_blank;
    logic [3:0]         w_row, w_col;
    logic [1:0]         w_code;

    assign w_dx     = $signed({2'b00, requested_x}) - $signed({2'b00, r_car_x});
    assign w_dy     = $signed({2'b00, requested_y}) - $signed({r_car_y[11], r_car_y});
    assign w_inside = car_active && (w_dx >= 13'sd0) && (w_dx < CAR_SZ)
                                 && (w_dy >= 13'sd0) && (w_dy < CAR_SZ);
    assign w_row    = w_dy[SCALE_LOG2 +: 4];
    assign w_col    = w_dx[SCALE_LOG2 +: 4];
    assign w_code   = SPRITE[w_row][{w_col, 1'b0} +: 2];
    assign w_blank  = (r_state == S_CRASH) && r_crash_cnt[2];

    // p1: registered pixel answer, one cycle after the query
    always_ff @(posedge clk) begin
        if (reset || !w_inside || w_blank || w_code == 2'd0) begin
            r_draw_p1  <= 1'b0;
            r_color_p1 <= MASK_VALUE;
        end else begin
            r_draw_p1 <= 1'b1;
            case (w_code)
                2'd1:    r_color_p1 <= BODY_COLOR;
                2'd2:    r_color_p1 <= 8'h00;
                default: r_color_p1 <= 8'hFF;
            endcase
        end
    end

    assign car_x        = r_car_x;
    assign car_y        = r_car_y;
    assign car_active   = (r_state != S_WAIT);
    assign draw_request = r_draw_p1;
    assign output_color = r_color_p1;

endmodule

// File: tb/tb_ai_car_lane_gen.sv
// Bench for ai_car_lane_gen: directed vector table, hand-written lane-change and
// crash sequences, then random traffic against a behavioural car model.
module tb_ai_car_lane_gen;

    logic               clk = 1'b0;
    logic               reset, frame_start, hit;
    logic [10:0]        requested_x, requested_y, random;
    logic [9:0]         player_speed;
    logic [10:0]        car_x;
    logic signed [11:0] car_y;
    logic               car_active, draw_request;
    logic [7:0]         output_color;

    int n_chk = 0;
    int n_fail = 0;

    ai_car_lane_gen dut (
        .clk(clk), .reset(reset), .frame_start(frame_start),
        .requested_x(requested_x), .requested_y(requested_y),
        .player_speed(player_speed), .random(random), .hit(hit),
        .car_x(car_x), .car_y(car_y), .car_active(car_active),
        .draw_request(draw_request), .output_color(output_color)
    );

    always #5 clk = ~clk;

    // Behavioural model of the car, kept as plain integers and flags.
    bit m_active, m_shifting, m_crashed;
    int m_gap, m_x, m_y, m_lane, m_tgt, m_tgt_x, m_cc;
    logic       e_draw;
    logic [7:0] e_color;

    function automatic int code_at(int row, int col);
        if (row == 0 || row == 15 || col == 0 || col == 15) return 0;
        if (row == 1 || row == 14) return 3;
        if ((row == 4 || row == 5) && col >= 3 && col <= 12) return 2;
        return 1;
    endfunction

    task automatic model_pixel(output logic [7:0] col, output logic drw);
        int dx, dy, c;
        col = 8'h62;
        drw = 1'b0;
        dx = int'(requested_x) - m_x;
        dy = int'(requested_y) - m_y;
        if (!m_active || dx < 0 || dx >= 64 || dy < 0 || dy >= 64) return;
        if (m_crashed && ((m_cc / 4) % 2 == 1)) return;
        c = code_at(dy / 4, dx / 4);
        if (c == 0) return;
        drw = 1'b1;
        col = (c == 1) ? 8'hE4 : (c == 2) ? 8'h00 : 8'hFF;
    endtask

    task automatic model_despawn();
        m_active = 0;
        m_gap = int'(random[3:0]) + 1;
    endtask

    task automatic model_step();
        int ny, t;
        if (reset) begin
            m_active = 0; m_shifting = 0; m_crashed = 0;
            m_gap = 1; m_x = 180; m_y = -64; m_lane = 0;
            return;
        end
        if (!m_active) begin
            if (frame_start) begin
                if (m_gap == 0) begin
                    m_lane = int'(random) % 4;
                    m_x = 180 + 60 * m_lane;
                    m_y = -64;
                    m_active = 1; m_shifting = 0; m_crashed = 0;
                end else m_gap--;
            end
            return;
        end
        if (frame_start) begin
            ny = m_y + (int'(player_speed) >> 5) - 6;
            m_y = ny;
            if (ny >= 480 || ny < -64) begin
                model_despawn();
                return;
            end
        end
        if (m_crashed) begin
            if (frame_start) begin
                m_cc++;
                if (m_cc == 30) model_despawn();
            end
            return;
        end
        if (hit) begin
            m_crashed = 1; m_shifting = 0; m_cc = 0;
            return;
        end
        if (!frame_start) return;
        if (m_shifting) begin
            m_x += (m_tgt_x > m_x) ? 2 : -2;
            if (m_x == m_tgt_x) begin
                m_lane = m_tgt;
                m_shifting = 0;
            end
        end else if (random[10:8] == 3'd0) begin
            t = random[7] ? m_lane + 1 : m_lane - 1;
            if (t >= 0 && t < 4) begin
                m_shifting = 1; m_tgt = t; m_tgt_x = 180 + 60 * t;
            end
        end
    endtask

    task automatic tick();
        logic [7:0] ec;
        logic ed;
        if (reset) begin
            ec = 8'h62; ed = 1'b0;
        end else model_pixel(ec, ed);
        model_step();
        e_color = ec;
        e_draw = ed;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic signed [31:0] act, input int exp);
        n_chk++;
        if (act !== 32'(exp)) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic check_all();
        chk("car_active", car_active, int'(m_active));
        if (m_active) begin
            chk("car_x", car_x, m_x);
            chk("car_y", car_y, m_y);
        end
        chk("draw_request", draw_request, int'(e_draw));
        chk("output_color", output_color, int'(e_color));
    endtask

    task automatic frame(input logic [10:0] r, input logic [9:0] s, input logic h);
        frame_start = 1'b1; random = r; player_speed = s; hit = h;
        tick();
        frame_start = 1'b0; hit = 1'b0;
        check_all();
    endtask

    task automatic spawn(input logic [10:0] r);
        int n = 0;
        while (!car_active && n < 20) begin
            frame(r, 10'd192, 1'b0);
            n++;
        end
        chk("spawn_in_time", car_active, 1);
    endtask

    typedef struct {
        logic fs; logic [10:0] rnd; logic [9:0] spd; logic [10:0] qx, qy;
        logic eact; int ex; int ey; logic edraw; logic [7:0] ecol;
    } vec_t;
    vec_t tv[18];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        tv[0]  = '{1'b0, 11'h700, 10'd320,  11'd0,   11'd0,   1'b0, 180, -64, 1'b0, 8'h62};
        tv[1]  = '{1'b1, 11'h003, 10'd320,  11'd0,   11'd0,   1'b0, 180, -64, 1'b0, 8'h62};
        tv[2]  = '{1'b1, 11'h003, 10'd320,  11'd0,   11'd0,   1'b1, 360, -64, 1'b0, 8'h62};
        tv[3]  = '{1'b1, 11'h700, 10'd320,  11'd0,   11'd0,   1'b1, 360, -60, 1'b0, 8'h62};
        tv[4]  = '{1'b1, 11'h700, 10'd320,  11'd0,   11'd0,   1'b1, 360, -56, 1'b0, 8'h62};
        tv[5]  = '{1'b1, 11'h700, 10'd1023, 11'd0,   11'd0,   1'b1, 360, -31, 1'b0, 8'h62};
        tv[6]  = '{1'b1, 11'h700, 10'd1023, 11'd0,   11'd0,   1'b1, 360, -6,  1'b0, 8'h62};
        tv[7]  = '{1'b1, 11'h700, 10'd1023, 11'd0,   11'd0,   1'b1, 360, 19,  1'b0, 8'h62};
        tv[8]  = '{1'b1, 11'h700, 10'd1023, 11'd0,   11'd0,   1'b1, 360, 44,  1'b0, 8'h62};
        tv[9]  = '{1'b0, 11'h700, 10'd1023, 11'd380, 11'd56,  1'b1, 360, 44,  1'b1, 8'hE4};
        tv[10] = '{1'b0, 11'h700, 10'd1023, 11'd380, 11'd61,  1'b1, 360, 44,  1'b1, 8'h00};
        tv[11] = '{1'b0, 11'h700, 10'd1023, 11'd368, 11'd48,  1'b1, 360, 44,  1'b1, 8'hFF};
        tv[12] = '{1'b0, 11'h700, 10'd1023, 11'd361, 11'd74,  1'b1, 360, 44,  1'b0, 8'h62};
        tv[13] = '{1'b0, 11'h700, 10'd1023, 11'd424, 11'd74,  1'b1, 360, 44,  1'b0, 8'h62};
        tv[14] = '{1'b0, 11'h700, 10'd1023, 11'd359, 11'd74,  1'b1, 360, 44,  1'b0, 8'h62};
        tv[15] = '{1'b0, 11'h700, 10'd1023, 11'd390, 11'd107, 1'b1, 360, 44,  1'b0, 8'h62};
        tv[16] = '{1'b0, 11'h700, 10'd1023, 11'd419, 11'd103, 1'b1, 360, 44,  1'b1, 8'hFF};
        tv[17] = '{1'b0, 11'h700, 10'd1023, 11'd380, 11'd43,  1'b1, 360, 44,  1'b0, 8'h62};

        reset = 1'b1; frame_start = 1'b0; hit = 1'b0;
        requested_x = 11'd0; requested_y = 11'd0; random = 11'h700; player_speed = 10'd0;
        tick();
        tick();
        reset = 1'b0;

        for (int i = 0; i < 18; i++) begin
            frame_start = tv[i].fs; random = tv[i].rnd; player_speed = tv[i].spd;
            requested_x = tv[i].qx; requested_y = tv[i].qy; hit = 1'b0;
            tick();
            frame_start = 1'b0;
            chk($sformatf("vec%0d_active", i), car_active, int'(tv[i].eact));
            chk($sformatf("vec%0d_x", i), car_x, tv[i].ex);
            chk($sformatf("vec%0d_y", i), car_y, tv[i].ey);
            chk($sformatf("vec%0d_draw", i), draw_request, int'(tv[i].edraw));
            chk($sformatf("vec%0d_color", i), output_color, int'(tv[i].ecol));
        end

        // Scroll off the bottom.
        requested_x = 11'd0; requested_y = 11'd0;
        for (int n = 0; n < 30 && car_active; n++) frame(11'h700, 10'd1023, 1'b0);
        chk("bottom_despawn", car_active, 0);

        // Spawn in lane 2, then fall off the top on the first slow frame.
        spawn(11'h702);
        chk("spawn_lane2_x", car_x, 300);
        chk("spawn_lane2_y", car_y, -64);
        frame(11'h700, 10'd0, 1'b0);
        chk("top_despawn", car_active, 0);

        // Lane 1 -> 2 -> 3 shifts, blocked shift at the edge, then crash mid-shift.
        spawn(11'h701);
        chk("spawn_lane1_x", car_x, 240);
        repeat (4) frame(11'h700, 10'd1023, 1'b0);
        chk("pre_shift_y", car_y, 36);
        frame(11'h080, 10'd192, 1'b0);
        chk("shift_start_x", car_x, 240);
        for (int k = 1; k <= 30; k++) begin
            frame(11'h700, 10'd192, 1'b0);
            chk("shift_x", car_x, 240 + 2 * k);
        end
        frame(11'h080, 10'd192, 1'b0);
        frame(11'h700, 10'd192, 1'b0);
        chk("shift2_first_x", car_x, 302);
        repeat (29) frame(11'h700, 10'd192, 1'b0);
        chk("shift2_end_x", car_x, 360);
        frame(11'h080, 10'd192, 1'b0);
        frame(11'h700, 10'd192, 1'b0);
        chk("lane3_no_shift", car_x, 360);
        frame(11'h000, 10'd192, 1'b0);
        frame(11'h700, 10'd192, 1'b0);
        chk("shift_down_x", car_x, 358);
        frame(11'h700, 10'd320, 1'b1);
        chk("crash_x_frozen", car_x, 358);
        chk("crash_y_scrolled", car_y, 40);

        requested_x = 11'd378; requested_y = 11'd52;
        for (int k = 0; k < 30; k++) begin
            hit = (k == 10);
            tick();
            hit = 1'b0;
            check_all();
            chk("blink_color", output_color, ((k / 4) % 2 == 1) ? 32'h62 : 32'hE4);
            chk("crash_x", car_x, 358);
            frame(11'h700, 10'd192, 1'b0);
        end
        chk("crash_end", car_active, 0);
        hit = 1'b1;
        tick();
        hit = 1'b0;
        check_all();
        chk("hit_in_wait", car_active, 0);

        // Random traffic with one reset in the middle.
        for (int i = 0; i < 4000; i++) begin
            int qx, qy;
            reset = (i == 2000);
            frame_start = ($urandom_range(0, 3) == 0);
            hit = ($urandom_range(0, 40) == 0);
            random = 11'($urandom);
            player_speed = 10'($urandom);
            if (m_active) begin
                qx = m_x + int'($urandom_range(0, 80)) - 8;
                qy = m_y + int'($urandom_range(0, 80)) - 8;
            end else begin
                qx = int'($urandom_range(0, 639));
                qy = int'($urandom_range(0, 479));
            end
            requested_x = 11'(qx);
            requested_y = 11'(qy);
            tick();
            check_all();
            if (reset) begin
                chk("mid_reset_active", car_active, 0);
                chk("mid_reset_x", car_x, 180);
                chk("mid_reset_y", car_y, -64);
                chk("mid_reset_draw", draw_request, 0);
                chk("mid_reset_color", output_color, 32'h62);
            end
        end
        reset = 1'b0; frame_start = 1'b0; hit = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
